// File: rtl/if_id_stage_if.sv
// Signal bundle between the fetch stage and its neighbours (instruction
// memory, EX redirect, ID/EX hazard view, decode-side IF/ID outputs).
interface if_id_stage_if;
  // Flow: no backpressure handshake. valid_out qualifies the IF/ID contents;
  // stall_out=1 means IF/ID and PC hold this edge, idex_flush=1 means ID/EX
  // loads a bubble this edge. Redirects (branch_taken) win over stalls.
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        idex_MemRead;
  logic [4:0]  idex_rd;
  logic [31:0] pc_out;
  logic [31:0] pc_plus_4_out;
  logic [31:0] instr_out;
  logic [4:0]  rs1_out;
  logic [4:0]  rs2_out;
  logic [4:0]  rd_out;
  logic        valid_out;
  logic        stall_out;
  logic        idex_flush;
  logic [31:0] stall_count;
  logic [31:0] flush_count;

  modport master (
    output imem_rdata, branch_taken, branch_target, idex_MemRead, idex_rd,
    input  imem_addr, pc_out, pc_plus_4_out, instr_out, rs1_out, rs2_out,
           rd_out, valid_out, stall_out, idex_flush, stall_count, flush_count
  );

  modport slave (
    input  imem_rdata, branch_taken, branch_target, idex_MemRead, idex_rd,
    output imem_addr, pc_out, pc_plus_4_out, instr_out, rs1_out, rs2_out,
           rd_out, valid_out, stall_out, idex_flush, stall_count, flush_count
  );
endinterface

// File: rtl/if_id_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register, load-use
// hazard detection and saturating stall/flush event counters.
module if_id_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0040_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input logic         clk,
  input logic         reset,
  if_id_stage_if.slave bus
);
  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  logic [31:0] pc_q;
  logic [31:0] id_pc_q;
  logic [31:0] id_pc4_q;
  logic [31:0] id_instr_q;
  logic        id_valid_q;
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        load_use;
  logic        redirect;
  logic        stall;

  assign rs1 = id_instr_q[19:15];
  assign rs2 = id_instr_q[24:20];

  // Both source fields are compared for every format; an I-type whose
  // immediate bits alias rd costs a spurious stall, which is harmless.
  assign load_use = id_valid_q & bus.idex_MemRead & (bus.idex_rd != 5'd0) &
                    ((bus.idex_rd == rs1) | (bus.idex_rd == rs2));
  assign redirect = bus.branch_taken;
  assign stall    = load_use & ~redirect;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      id_pc_q    <= 32'd0;
      id_pc4_q   <= 32'd0;
      id_instr_q <= NOP_INSTR;
      id_valid_q <= 1'b0;
      stall_cnt  <= 32'd0;
      flush_cnt  <= 32'd0;
    end else if (redirect) begin
      pc_q       <= {bus.branch_target[31:2], 2'b00};
      id_pc_q    <= 32'd0;
      id_pc4_q   <= 32'd0;
      id_instr_q <= NOP_INSTR;
      id_valid_q <= 1'b0;
      if (flush_cnt != CNT_MAX) flush_cnt <= flush_cnt + 32'd1;
    end else if (stall) begin
      if (stall_cnt != CNT_MAX) stall_cnt <= stall_cnt + 32'd1;
    end else begin
      pc_q       <= pc_q + 32'd4;
      id_pc_q    <= pc_q;
      id_pc4_q   <= pc_q + 32'd4;
      id_instr_q <= bus.imem_rdata;
      id_valid_q <= 1'b1;
    end
  end

  assign bus.imem_addr     = pc_q;
  assign bus.pc_out        = id_pc_q;
  assign bus.pc_plus_4_out = id_pc4_q;
  assign bus.instr_out     = id_instr_q;
  assign bus.rs1_out       = rs1;
  assign bus.rs2_out       = rs2;
  assign bus.rd_out        = id_instr_q[11:7];
  assign bus.valid_out     = id_valid_q;
  assign bus.stall_out     = stall;
  assign bus.idex_flush    = load_use | redirect;
  assign bus.stall_count   = stall_cnt;
  assign bus.flush_count   = flush_cnt;
endmodule

// File: tb/tb_if_id_stage.sv
// Self-checking bench for if_id_stage: directed scenarios plus a randomized
// run compared against an instruction-level model of the fetch stage.
module tb_if_id_stage;
  localparam logic [31:0] RESET_PC = 32'h0040_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] MAX      = 32'hFFFF_FFFF;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  if_id_stage_if bus ();

  if_id_stage u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  // instruction memory contents: a few fixed words, the rest a scramble of the address
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0040_0000:                               return 32'h0050_0093;
      32'h0040_0004, 32'h0040_0100, 32'h0040_0200: return 32'h0020_8133;
      default:                                     return {a[15:0], a[31:16]} ^ 32'hA5C3_0F69;
    endcase
  endfunction

  assign bus.imem_rdata = mem_word(bus.imem_addr);

  // bench-held inputs
  logic        in_br;
  logic [31:0] in_tgt;
  logic        in_mr;
  logic [4:0]  in_rd;

  // reference model: architectural view of PC and IF/ID contents
  logic [31:0] m_pc, m_id_pc, m_id_pc4, m_instr, m_stall, m_flush;
  logic        m_valid;

  task automatic set_in(input logic b, input logic [31:0] t, input logic m, input logic [4:0] r);
    in_br = b; in_tgt = t; in_mr = m; in_rd = r;
    bus.branch_taken = b; bus.branch_target = t; bus.idex_MemRead = m; bus.idex_rd = r;
  endtask

  task automatic model_reset();
    m_pc = RESET_PC; m_id_pc = 0; m_id_pc4 = 0; m_instr = NOP; m_valid = 0;
    m_stall = 0; m_flush = 0;
  endtask

  function automatic logic m_hazard();
    return m_valid && in_mr && (in_rd != 0) &&
           (in_rd == m_instr[19:15] || in_rd == m_instr[24:20]);
  endfunction

  // advance model by one edge using current inputs, then clock the DUT
  task automatic tick();
    if (in_br) begin
      m_pc = {in_tgt[31:2], 2'b00}; m_instr = NOP; m_id_pc = 0; m_id_pc4 = 0; m_valid = 0;
      if (m_flush != MAX) m_flush = m_flush + 1;
    end else if (m_hazard()) begin
      if (m_stall != MAX) m_stall = m_stall + 1;
    end else begin
      m_id_pc = m_pc; m_id_pc4 = m_pc + 32'd4; m_instr = mem_word(m_pc); m_valid = 1;
      m_pc = m_pc + 32'd4;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_in(1'b0, 32'd0, 1'b0, 5'd0);
    model_reset();
    #1;
    checks++; if (bus.imem_addr !== RESET_PC) begin errors++; $display("FAIL rst_pc got=%h exp=%h", bus.imem_addr, RESET_PC); end
    checks++; if (bus.instr_out !== NOP) begin errors++; $display("FAIL rst_instr got=%h exp=%h", bus.instr_out, NOP); end
    checks++; if (bus.valid_out !== 1'b0 || bus.pc_out !== 32'd0 || bus.pc_plus_4_out !== 32'd0) begin
      errors++; $display("FAIL rst_ifid valid=%b pc=%h pc4=%h exp 0/0/0", bus.valid_out, bus.pc_out, bus.pc_plus_4_out); end
    checks++; if (bus.stall_count !== 32'd0 || bus.flush_count !== 32'd0) begin
      errors++; $display("FAIL rst_counts stall=%h flush=%h exp 0/0", bus.stall_count, bus.flush_count); end
    checks++; if (bus.stall_out !== 1'b0 || bus.idex_flush !== 1'b0) begin
      errors++; $display("FAIL rst_comb stall=%b flush=%b exp 0/0", bus.stall_out, bus.idex_flush); end
    set_in(1'b1, 32'h0000_1000, 1'b0, 5'd0);
    #1;
    checks++; if (bus.idex_flush !== 1'b1) begin errors++; $display("FAIL rst_br_flush got=%b exp=1", bus.idex_flush); end
    set_in(1'b0, 32'd0, 1'b0, 5'd0);
    @(negedge clk);
  endtask

  task automatic test_first_fetch();
    reset = 1'b0;
    tick();
    checks++; if (bus.instr_out !== 32'h0050_0093) begin errors++; $display("FAIL ff_instr got=%h exp=%h", bus.instr_out, 32'h0050_0093); end
    checks++; if (bus.pc_out !== 32'h0040_0000 || bus.pc_plus_4_out !== 32'h0040_0004) begin
      errors++; $display("FAIL ff_pc pc=%h pc4=%h exp 00400000/00400004", bus.pc_out, bus.pc_plus_4_out); end
    checks++; if (bus.valid_out !== 1'b1) begin errors++; $display("FAIL ff_valid got=%b exp=1", bus.valid_out); end
    tick();
    checks++; if (bus.imem_addr !== 32'h0040_0008) begin errors++; $display("FAIL ff_addr2 got=%h exp=00400008", bus.imem_addr); end
    checks++; if (bus.instr_out !== 32'h0020_8133) begin errors++; $display("FAIL ff_instr2 got=%h exp=00208133", bus.instr_out); end
  endtask

  task automatic test_load_use();
    set_in(1'b0, 32'd0, 1'b1, 5'd1);
    #1;
    checks++; if (bus.stall_out !== 1'b1 || bus.idex_flush !== 1'b1) begin
      errors++; $display("FAIL lu_comb stall=%b flush=%b exp 1/1", bus.stall_out, bus.idex_flush); end
    tick();
    checks++; if (bus.imem_addr !== 32'h0040_0008 || bus.instr_out !== 32'h0020_8133 || bus.pc_out !== 32'h0040_0004) begin
      errors++; $display("FAIL lu_hold addr=%h instr=%h pc=%h exp 00400008/00208133/00400004", bus.imem_addr, bus.instr_out, bus.pc_out); end
    checks++; if (bus.stall_count !== 32'd1) begin errors++; $display("FAIL lu_count got=%h exp=1", bus.stall_count); end
    set_in(1'b0, 32'd0, 1'b1, 5'd2);
    #1;
    checks++; if (bus.stall_out !== 1'b1) begin errors++; $display("FAIL lu_rs2 got=%b exp=1", bus.stall_out); end
    set_in(1'b0, 32'd0, 1'b1, 5'd0);
    #1;
    checks++; if (bus.stall_out !== 1'b0 || bus.idex_flush !== 1'b0) begin
      errors++; $display("FAIL lu_rd0 stall=%b flush=%b exp 0/0", bus.stall_out, bus.idex_flush); end
    set_in(1'b0, 32'd0, 1'b0, 5'd0);
    tick();
    checks++; if (bus.imem_addr !== m_pc || bus.stall_count !== m_stall) begin
      errors++; $display("FAIL lu_resume addr=%h cnt=%h exp %h/%h", bus.imem_addr, bus.stall_count, m_pc, m_stall); end
  endtask

  task automatic test_branch();
    set_in(1'b1, 32'h0040_0103, 1'b0, 5'd0);
    #1;
    checks++; if (bus.idex_flush !== 1'b1 || bus.stall_out !== 1'b0) begin
      errors++; $display("FAIL br_comb flush=%b stall=%b exp 1/0", bus.idex_flush, bus.stall_out); end
    tick();
    checks++; if (bus.imem_addr !== 32'h0040_0100) begin errors++; $display("FAIL br_pc got=%h exp=00400100", bus.imem_addr); end
    checks++; if (bus.instr_out !== NOP || bus.valid_out !== 1'b0 || bus.pc_out !== 32'd0) begin
      errors++; $display("FAIL br_ifid instr=%h valid=%b pc=%h exp 00000013/0/0", bus.instr_out, bus.valid_out, bus.pc_out); end
    checks++; if (bus.flush_count !== 32'd1) begin errors++; $display("FAIL br_count got=%h exp=1", bus.flush_count); end
  endtask

  task automatic test_branch_and_load_use();
    set_in(1'b0, 32'd0, 1'b0, 5'd0);
    tick();
    set_in(1'b1, 32'h0040_0200, 1'b1, 5'd2);
    #1;
    checks++; if (bus.stall_out !== 1'b0 || bus.idex_flush !== 1'b1) begin
      errors++; $display("FAIL bl_comb stall=%b flush=%b exp 0/1", bus.stall_out, bus.idex_flush); end
    tick();
    checks++; if (bus.imem_addr !== 32'h0040_0200) begin errors++; $display("FAIL bl_pc got=%h exp=00400200", bus.imem_addr); end
    checks++; if (bus.stall_count !== 32'd1 || bus.flush_count !== 32'd2) begin
      errors++; $display("FAIL bl_counts stall=%h flush=%h exp 1/2", bus.stall_count, bus.flush_count); end
  endtask

  task automatic test_reset_mid_stall();
    set_in(1'b0, 32'd0, 1'b0, 5'd0);
    tick();
    set_in(1'b0, 32'd0, 1'b1, 5'd1);
    #1;
    checks++; if (bus.stall_out !== 1'b1) begin errors++; $display("FAIL rms_pre got=%b exp=1", bus.stall_out); end
    #2 reset = 1'b1;
    #1;
    checks++; if (bus.imem_addr !== RESET_PC || bus.instr_out !== NOP || bus.valid_out !== 1'b0) begin
      errors++; $display("FAIL rms_state addr=%h instr=%h valid=%b exp %h/%h/0", bus.imem_addr, bus.instr_out, bus.valid_out, RESET_PC, NOP); end
    checks++; if (bus.stall_out !== 1'b0 || bus.idex_flush !== 1'b0 || bus.stall_count !== 0 || bus.flush_count !== 0) begin
      errors++; $display("FAIL rms_misc stall=%b flush=%b sc=%h fc=%h exp 0/0/0/0", bus.stall_out, bus.idex_flush, bus.stall_count, bus.flush_count); end
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    set_in(1'b0, 32'd0, 1'b0, 5'd0);
  endtask

  task automatic test_counter_saturation();
    tick();
    set_in(1'b0, 32'd0, 1'b1, 5'd5);
    force u_dut.stall_cnt = 32'hFFFF_FFFE;
    #1;
    release u_dut.stall_cnt;
    m_stall = 32'hFFFF_FFFE;
    #1;
    checks++; if (bus.stall_count !== 32'hFFFF_FFFE) begin errors++; $display("FAIL sat_preload got=%h exp=fffffffe", bus.stall_count); end
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (bus.stall_count !== m_stall || bus.imem_addr !== m_pc) begin
        errors++; $display("FAIL sat_step%0d cnt=%h addr=%h exp %h/%h", i, bus.stall_count, bus.imem_addr, m_stall, m_pc); end
    end
    set_in(1'b0, 32'd0, 1'b0, 5'd0);
  endtask

  task automatic test_random();
    logic [31:0] t;
    logic [4:0]  r;
    logic        exp_lu;
    reset = 1'b1;
    #1 model_reset();
    @(negedge clk);
    reset = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      t = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      case ($urandom_range(0, 3))
        0:       r = m_instr[19:15];
        1:       r = m_instr[24:20];
        2:       r = 5'd0;
        default: r = 5'($urandom_range(0, 31));
      endcase
      set_in($urandom_range(0, 7) == 0, t, $urandom_range(0, 1) == 1, r);
      #1;
      exp_lu = m_hazard();
      checks++; if (bus.stall_out !== (exp_lu && !in_br) || bus.idex_flush !== (exp_lu || in_br)) begin
        errors++; $display("FAIL rnd_comb cyc=%0d stall=%b flush=%b exp %b/%b", cyc, bus.stall_out, bus.idex_flush, exp_lu && !in_br, exp_lu || in_br); end
      checks++; if (bus.imem_addr !== m_pc || bus.pc_out !== m_id_pc || bus.pc_plus_4_out !== m_id_pc4) begin
        errors++; $display("FAIL rnd_pc cyc=%0d addr=%h pc=%h pc4=%h exp %h/%h/%h", cyc, bus.imem_addr, bus.pc_out, bus.pc_plus_4_out, m_pc, m_id_pc, m_id_pc4); end
      checks++; if (bus.instr_out !== m_instr || bus.valid_out !== m_valid || bus.rd_out !== m_instr[11:7] ||
                    bus.rs1_out !== m_instr[19:15] || bus.rs2_out !== m_instr[24:20]) begin
        errors++; $display("FAIL rnd_ifid cyc=%0d instr=%h valid=%b exp %h/%b", cyc, bus.instr_out, bus.valid_out, m_instr, m_valid); end
      checks++; if (bus.stall_count !== m_stall || bus.flush_count !== m_flush) begin
        errors++; $display("FAIL rnd_counts cyc=%0d stall=%h flush=%h exp %h/%h", cyc, bus.stall_count, bus.flush_count, m_stall, m_flush); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_load_use();
    test_branch();
    test_branch_and_load_use();
    test_reset_mid_stall();
    test_counter_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/if_id_stage.md
# if_id_stage

Instruction-fetch stage of the 5-stage RISC-V pipeline: owns the PC register, the IF/ID pipeline register and the load-use hazard detector, and feeds the decode stage that drives the ID/EX register. Applies branch redirects from EX, inserts load-use stalls, and generates the bubble/flush request for ID/EX. Keeps saturating stall and flush event counters for performance debugging.

## Interface

- RESET_PC, 32'h0040_0000, PC value loaded on reset
- NOP_INSTR, 32'h0000_0013, instruction word (addi x0,x0,0) held in IF/ID when empty or flushed

- clk  in  1  pipeline clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- imem_addr  out  32  current PC, to instruction memory
- imem_rdata  in  32  instruction at imem_addr, combinational read, valid same cycle
- branch_taken  in  1  EX-stage redirect request
- branch_target  in  32  EX-stage redirect address
- idex_MemRead  in  1  MemRead currently held in ID/EX
- idex_rd  in  5  rd currently held in ID/EX
- pc_out  out  32  PC of instruction in IF/ID
- pc_plus_4_out  out  32  pc_out + 4
- instr_out  out  32  instruction in IF/ID
- rs1_out / rs2_out / rd_out  out  5 each  instr_out[19:15] / [24:20] / [11:7], combinational from register
- valid_out  out  1  IF/ID holds a real instruction
- stall_out  out  1  load-use stall applied this cycle
- idex_flush  out  1  ID/EX must load a bubble next edge
- stall_count / flush_count  out  32 each  saturating event counters

## Operation

- load_use = valid_out & idex_MemRead & (idex_rd != 0) & (idex_rd == rs1_out | idex_rd == rs2_out); both fields compared unconditionally regardless of format (false stalls on I-type accepted).
- stall_out = load_use & ~branch_taken.
- idex_flush = load_use | branch_taken.
- Per rising edge, priority high to low:
  - branch_taken: PC <= {branch_target[31:2], 2'b00}; instr_out <= NOP_INSTR; pc_out, pc_plus_4_out <= 0; valid_out <= 0; flush_count += 1.
  - stall_out: PC and all IF/ID fields hold; stall_count += 1.
  - otherwise: PC <= PC + 4 (mod 2^32); pc_out <= PC; pc_plus_4_out <= PC + 4; instr_out <= imem_rdata; valid_out <= 1.
- Counters saturate at 32'hFFFF_FFFF; no wrap.
- PC wraps 32'hFFFF_FFFC -> 32'h0000_0000 silently.
- imem_addr = PC at all times.

## Timing

- Reset (async, immediate): PC = RESET_PC, instr_out = NOP_INSTR, pc_out = pc_plus_4_out = 0, valid_out = 0, both counters 0; stall_out = idex_flush = 0 as consequence (valid_out = 0, branch_taken excepted—idex_flush follows branch_taken combinationally even in reset).
- First fetch: instruction at RESET_PC appears on instr_out one edge after reset deasserts.
- Fetch-to-IF/ID latency: 1 cycle. Throughput: 1 instruction/cycle without hazards.
- Load-use: exactly 1 stall cycle per hazard (ID/EX bubble clears idex_MemRead next cycle).
- Branch penalty: 2 cycles (IF/ID and ID/EX both flushed at same edge).
- Branch and load-use simultaneously: branch wins; PC redirected, no stall counted, flush counted.
- Reset asserted mid-stall or mid-redirect: state clears immediately; pending redirect lost.
- stall_out, idex_flush, rs*/rd_out are combinational; no registered outputs other than PC, IF/ID fields, counters.

## Test plan

- Reset release, imem returns 0x00500093 at 0x00400000 -> after 1 edge instr_out=0x00500093, pc_out=0x00400000, pc_plus_4_out=0x00400004, valid_out=1, imem_addr=0x00400008 after 2 edges.
- Load-use: IF/ID holds 0x00208133 (add x2,x1,x2), idex_MemRead=1, idex_rd=1 -> stall_out=1, idex_flush=1, PC/IF/ID held one edge, stall_count=1; with idex_rd=0 -> no stall.
- Branch: branch_taken=1, branch_target=0x00400103 -> next edge PC=0x00400100, instr_out=0x00000013, valid_out=0, flush_count=1.
- Simultaneous branch and load-use -> PC=branch target, stall_count unchanged, flush_count+1, idex_flush=1.
- Reset asserted mid-cycle during stall -> outputs return to reset values without waiting for clk edge.
- Force stall_count to 0xFFFFFFFE, apply 3 stall cycles -> stays 0xFFFFFFFF.
